// File: rtl/qam16_coherent_demod.sv
// Coherent 16-QAM demodulator: mixes rx with sin/cos references, integrates one symbol, slices to a Gray 4-bit code.
// Latency: sym_valid rises one cycle after the edge that accepts the last sample of a symbol.
// Backpressure: in_ready drops only in the one SLICE cycle; an unconsumed symbol is overwritten and flags a sticky overrun.
module qam16_coherent_demod #(
    parameter int SYMBOL_LEN = 360,
    parameter int ACC_W      = 25,
    parameter int THRESH     = 900000
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic signed [7:0]       rx_sample,
    input  logic signed [7:0]       ref_sin,
    input  logic signed [7:0]       ref_cos,
    input  logic                    in_valid,
    input  logic                    sym_start,
    output logic                    in_ready,
    output logic [3:0]              sym_out,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_q,
    output logic                    overrun
);

    localparam int CW = $clog2(SYMBOL_LEN + 1);
    localparam logic [CW-1:0]          LAST  = CW'(SYMBOL_LEN);
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SLICE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic signed [ACC_W-1:0] sum_i_q;
    logic signed [ACC_W-1:0] sum_q_q;
    logic signed [ACC_W-1:0] sum_i_d;
    logic signed [ACC_W-1:0] sum_q_d;
    logic signed [ACC_W-1:0] acc_i_q;
    logic signed [ACC_W-1:0] acc_q_q;
    logic [3:0]              sym_out_q;
    logic                    sym_valid_q;
    logic                    overrun_q;
    logic                    in_ready_q;

    logic signed [15:0]      rx_w;
    logic signed [15:0]      sin_w;
    logic signed [15:0]      cos_w;
    logic signed [15:0]      prod_i;
    logic signed [15:0]      prod_q;
    logic signed [ACC_W-1:0] prod_i_ext;
    logic signed [ACC_W-1:0] prod_q_ext;
    logic                    accept;
    logic                    load;

    // Widen operands first so the 16-bit product is the exact 8x8 signed result.
    assign rx_w       = 16'(rx_sample);
    assign sin_w      = 16'(ref_sin);
    assign cos_w      = 16'(ref_cos);
    assign prod_i     = rx_w * sin_w;
    assign prod_q     = rx_w * cos_w;
    assign prod_i_ext = {{(ACC_W-16){prod_i[15]}}, prod_i};
    assign prod_q_ext = {{(ACC_W-16){prod_q[15]}}, prod_q};

    assign accept = in_valid && in_ready_q;
    // A sym_start (first sample or resync) or the first sample after SLICE restarts the sums.
    assign load   = sym_start || (cnt_q == '0);

    // Next accumulator/count values for an accepted sample.
    always_comb begin
        sum_i_d = sum_i_q + prod_i_ext;
        sum_q_d = sum_q_q + prod_q_ext;
        cnt_d   = cnt_q + 1'b1;
        if (load) begin
            sum_i_d = prod_i_ext;
            sum_q_d = prod_q_ext;
            cnt_d   = CW'(1);
        end
    end

    // Four-level slicer: boundaries at -THRESH, 0 and +THRESH, ties go to the upper region.
    function automatic logic [1:0] slice2(input logic signed [ACC_W-1:0] v);
        if (v >= THR_P)
            return 2'b10;
        else if (v >= 0)
            return 2'b11;
        else if (v >= THR_N)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Control FSM with integrators, output register and handshake.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sum_i_q     <= '0;
            sum_q_q     <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (sym_valid_q && sym_ready)
                sym_valid_q <= 1'b0;

            case (state_q)
                IDLE, ACCUM: begin
                    if (accept && (sym_start || state_q == ACCUM)) begin
                        sum_i_q <= sum_i_d;
                        sum_q_q <= sum_q_d;
                        cnt_q   <= cnt_d;
                        if (cnt_d == LAST) begin
                            state_q    <= SLICE;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                SLICE: begin
                    acc_i_q     <= sum_i_q;
                    acc_q_q     <= sum_q_q;
                    sym_out_q   <= {slice2(sum_i_q), slice2(sum_q_q)};
                    sym_valid_q <= 1'b1;
                    if (sym_valid_q && !sym_ready)
                        overrun_q <= 1'b1;
                    sum_i_q     <= '0;
                    sum_q_q     <= '0;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ACCUM;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign acc_i     = acc_i_q;
    assign acc_q     = acc_q_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_qam16_coherent_demod.sv
// Directed bench for the 16-QAM coherent demodulator with an expected-symbol queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled then or on the falling edge.
// Emitted symbols are popped from the queue and compared whenever sym_valid && sym_ready.
module tb_qam16_coherent_demod;

    localparam int SL = 360;
    localparam int AW = 25;
    localparam int TH = 900000;
    localparam real PI = 3.14159265358979;

    logic                 Clk;
    logic                 Rst_n;
    logic signed [7:0]    rx_sample;
    logic signed [7:0]    ref_sin;
    logic signed [7:0]    ref_cos;
    logic                 in_valid;
    logic                 sym_start;
    logic                 in_ready;
    logic [3:0]           sym_out;
    logic                 sym_valid;
    logic                 sym_ready;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic                 overrun;

    qam16_coherent_demod #(.SYMBOL_LEN(SL), .ACC_W(AW), .THRESH(TH)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .rx_sample(rx_sample), .ref_sin(ref_sin), .ref_cos(ref_cos),
        .in_valid(in_valid), .sym_start(sym_start), .in_ready(in_ready), .sym_out(sym_out),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .acc_i(acc_i), .acc_q(acc_q), .overrun(overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] sym;
        longint     ai;
        longint     aq;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   ir_low   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [1:0] gray(input int lvl);
        case (lvl)
            3:       return 2'b10;
            1:       return 2'b11;
            -1:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Scoreboard: every handshake must match the oldest expected symbol.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (!in_ready)
                ir_low++;
            if (sym_valid && sym_ready) begin
                checks++;
                assert (sbq.size() != 0) else begin
                    failures++;
                    $error("FAIL sym_unexpected observed=%0h expected=none", sym_out);
                end
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_sym_out", {60'd0, sym_out}, {60'd0, e.sym});
                    chk("sb_acc_i", acc_i, e.ai);
                    chk("sb_acc_q", acc_q, e.aq);
                end
            end
        end
    end

    task automatic put_sample(input int r, input int s, input int c, input bit st);
        int b;
        rx_sample = 8'(r);
        ref_sin   = 8'(s);
        ref_cos   = 8'(c);
        in_valid  = 1'b1;
        sym_start = st;
        b = 0;
        while (!in_ready && b < 8) begin
            @(posedge Clk); #1;
            b++;
        end
        if (!in_ready)
            chk("in_ready_timeout", {63'd0, in_ready}, 64'sd1);
        @(posedge Clk); #1;
        in_valid  = 1'b0;
        sym_start = 1'b0;
    endtask

    task automatic gap_cycle();
        in_valid  = 1'b0;
        rx_sample = 8'($urandom);
        sym_start = 1'($urandom_range(0, 1));
        @(posedge Clk); #1;
        sym_start = 1'b0;
    endtask

    // One symbol at levels (li, lq); optional abort prefix of abort_at samples of another symbol.
    task automatic send_sym(input int li, input int lq, input bit gaps, input bit lat, input int abort_at);
        longint si, sq;
        int     r, s, c;
        real    th;
        for (int n = 0; n < abort_at; n++) begin
            th = 2.0 * PI * n / SL;
            put_sample(rnd(25.0 * (-li * $sin(th) - lq * $cos(th))),
                       rnd(100.0 * $sin(th)), rnd(100.0 * $cos(th)), n == 0);
        end
        si = 0;
        sq = 0;
        for (int n = 0; n < SL; n++) begin
            th = 2.0 * PI * n / SL;
            s  = rnd(100.0 * $sin(th));
            c  = rnd(100.0 * $cos(th));
            r  = rnd(25.0 * (li * $sin(th) + lq * $cos(th)));
            if (gaps && (n % 2 == 1))
                gap_cycle();
            put_sample(r, s, c, n == 0);
            si += r * s;
            sq += r * c;
        end
        sbq.push_back('{sym: {gray(li), gray(lq)}, ai: si, aq: sq});
        chk("slice_in_ready_low", {63'd0, in_ready}, 64'sd0);
        if (lat) begin
            chk("lat_valid_pre", {63'd0, sym_valid}, 64'sd0);
            @(posedge Clk); #1;
            chk("lat_valid_rise", {63'd0, sym_valid}, 64'sd1);
            chk("lat_in_ready_back", {63'd0, in_ready}, 64'sd1);
            @(posedge Clk); #1;
            chk("lat_valid_one_cycle", {63'd0, sym_valid}, 64'sd0);
        end
    endtask

    task automatic send_const(input int r, input int s, input int c, input logic [3:0] es);
        for (int n = 0; n < SL; n++)
            put_sample(r, s, c, n == 0);
        sbq.push_back('{sym: es, ai: longint'(r * s * SL), aq: longint'(r * c * SL)});
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        int lv[4];
        int ir0;
        lv = '{-3, -1, 1, 3};
        Rst_n = 1'b1; rx_sample = '0; ref_sin = '0; ref_cos = '0;
        in_valid = 1'b0; sym_start = 1'b0; sym_ready = 1'b1;

        // Reset values
        #2 Rst_n = 1'b0;
        #1;
        chk("rst_sym_valid", {63'd0, sym_valid}, 64'sd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'sd1);
        chk("rst_overrun", {63'd0, overrun}, 64'sd0);
        chk("rst_sym_out", {60'd0, sym_out}, 64'sd0);
        chk("rst_acc_i", acc_i, 64'sd0);
        wait_cycles(3);
        Rst_n = 1'b1;
        wait_cycles(1);

        // Single symbol I=+3 Q=-1 with latency checks
        send_sym(3, -1, 1'b0, 1'b1, 0);
        chk("t2_sym_out", {60'd0, sym_out}, 64'sd9);
        chk("t2_acc_i_near", {63'd0, (acc_i > 1340000) && (acc_i < 1360000)}, 64'sd1);
        chk("t2_acc_q_near", {63'd0, (acc_q > -460000) && (acc_q < -440000)}, 64'sd1);

        // All 16 symbols back-to-back with in_valid toggling
        ir0 = ir_low;
        for (int i = 0; i < 16; i++)
            send_sym(lv[i / 4], lv[i % 4], 1'b1, 1'b0, 0);
        wait_cycles(3);
        chk("t3_in_ready_low_cycles", ir_low - ir0, 64'sd16);
        chk("t3_sb_drained", sbq.size(), 64'sd0);

        // Backpressure and overrun
        sym_ready = 1'b0;
        send_sym(1, 1, 1'b0, 1'b0, 0);
        wait_cycles(2);
        chk("t4_held_valid", {63'd0, sym_valid}, 64'sd1);
        chk("t4_held_sym", {60'd0, sym_out}, 64'sd15);
        chk("t4_no_overrun_yet", {63'd0, overrun}, 64'sd0);
        send_sym(-3, 3, 1'b0, 1'b0, 0);
        sbq.delete(0);
        wait_cycles(2);
        chk("t4_overrun_set", {63'd0, overrun}, 64'sd1);
        chk("t4_second_sym", {60'd0, sym_out}, 64'sd2);
        sym_ready = 1'b1;
        wait_cycles(1);
        chk("t4_valid_dropped", {63'd0, sym_valid}, 64'sd0);
        chk("t4_overrun_sticky", {63'd0, overrun}, 64'sd1);

        // Resync at sample 100
        send_sym(-1, -3, 1'b0, 1'b0, 100);
        wait_cycles(3);
        chk("t5_sb_drained", sbq.size(), 64'sd0);

        // Exact slicer boundaries: +THRESH, 0, -THRESH
        send_const(50, 50, -50, 4'b1001);
        send_const(0, 50, 50, 4'b1111);
        send_const(-50, 50, 50, 4'b0101);
        wait_cycles(3);
        chk("t6_sb_drained", sbq.size(), 64'sd0);

        // Asynchronous reset in the middle of a symbol, with a held output
        sym_ready = 1'b0;
        send_sym(3, 3, 1'b0, 1'b0, 0);
        wait_cycles(2);
        chk("t1_pre_valid", {63'd0, sym_valid}, 64'sd1);
        for (int n = 0; n < 200; n++)
            put_sample(60, 40, -40, n == 0);
        #3 Rst_n = 1'b0;
        #1;
        chk("t1_rst_sym_valid", {63'd0, sym_valid}, 64'sd0);
        chk("t1_rst_sym_out", {60'd0, sym_out}, 64'sd0);
        chk("t1_rst_acc_i", acc_i, 64'sd0);
        chk("t1_rst_acc_q", acc_q, 64'sd0);
        chk("t1_rst_overrun", {63'd0, overrun}, 64'sd0);
        sbq.delete();
        wait_cycles(2);
        Rst_n = 1'b1;
        sym_ready = 1'b1;
        chk("t1_in_ready_after", {63'd0, in_ready}, 64'sd1);
        for (int n = 0; n < 400; n++)
            put_sample(70, 50, 50, 1'b0);
        wait_cycles(2);
        chk("t1_idle_no_valid", {63'd0, sym_valid}, 64'sd0);
        send_sym(-1, 3, 1'b0, 1'b1, 0);
        wait_cycles(3);
        chk("final_sb_drained", sbq.size(), 64'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qam16_coherent_demod.md
Name: qam16_coherent_demod

Overview:
- Receive-side counterpart of the carrier generator and modulator: coherently demodulates a 16-QAM passband sample stream back into 4-bit symbols.
- Multiplies each received sample by locally supplied, phase-aligned sine/cosine reference samples and integrates over one symbol period.
- Slices the I/Q integrals into Gray-coded 4-bit symbols, delivered through a valid/ready output port.
- Sits between the ADC/channel model and the bit-unpacker.

Parameters:
SYMBOL_LEN, 360, samples per symbol (one full carrier period)
ACC_W, 25, signed accumulator width; must hold 127*127*SYMBOL_LEN plus sign
THRESH, 900000, outer slicer threshold; inner threshold fixed at 0

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
rx_sample  input  8  signed received passband sample
ref_sin  input  8  signed in-phase reference sample, aligned with rx_sample
ref_cos  input  8  signed quadrature reference sample, aligned with rx_sample
in_valid  input  1  rx_sample/ref_sin/ref_cos valid this cycle
sym_start  input  1  qualifies the current valid sample as the first sample of a symbol
in_ready  output  1  block accepts a sample this cycle
sym_out  output  4  {I bits[3:2], Q bits[1:0]}, Gray coded
sym_valid  output  1  sym_out, acc_i and acc_q are valid
sym_ready  input  1  downstream accepts sym_out
acc_i  output  ACC_W  signed I integral of the last completed symbol
acc_q  output  ACC_W  signed Q integral of the last completed symbol
overrun  output  1  sticky: a completed symbol overwrote an unconsumed one

Behaviour:
- Reset is asynchronous, active-low, and applies mid-operation without exception.
  - Reset values: state IDLE, sample counter 0, internal accumulators 0, sym_out 0, acc_i 0, acc_q 0, sym_valid 0, overrun 0, in_ready 1.
  - Any partial symbol is discarded.
- A sample is accepted on a rising edge when in_valid && in_ready.
- State machine:
  - IDLE: in_ready=1. Accepted samples without sym_start are dropped. An accepted sample with sym_start loads accI=rx*ref_sin, accQ=rx*ref_cos, sets count=1, and moves to ACCUM.
  - ACCUM: in_ready=1. Each accepted sample adds rx*ref_sin to accI and rx*ref_cos to accQ (8x8 signed to 16-bit, sign-extended to ACC_W), then increments count.
    - If the accepted sample brings count to SYMBOL_LEN, move to SLICE.
    - If an accepted sample has sym_start while count is in 1..SYMBOL_LEN-1, it is a resync: the partial sums are discarded, the accumulators are reloaded with this sample's products, and count=1. No symbol is emitted.
  - SLICE (exactly one cycle): in_ready=0.
    - Register acc_i=accI and acc_q=accQ, slice into sym_out, set sym_valid=1.
    - Clear accI, accQ and count, then go to ACCUM. Symbols stream back-to-back with no sym_start needed; the next accepted sample is sample 0 of the next symbol.
- Latency: sym_valid rises on the edge one cycle after the edge that accepted the last sample of a symbol.
- Slicer, applied identically to I and Q (v = acc value):
  - v >= THRESH gives 10
  - 0 <= v < THRESH gives 11
  - -THRESH <= v < 0 gives 01
  - v < -THRESH gives 00
  - Exactly 0 maps to 11; exactly THRESH maps to 10; exactly -THRESH maps to 01.
- Output handshake:
  - sym_valid holds, and sym_out/acc_i/acc_q stay stable, until the edge where sym_valid && sym_ready; sym_valid then drops.
  - If SLICE occurs while sym_valid=1 and sym_ready=0: the new symbol overwrites the held one, sym_valid stays 1, and overrun sets and stays set until reset.
  - If SLICE occurs while sym_valid=1 and sym_ready=1 in the same cycle: the old symbol is consumed, the new symbol is loaded, and overrun is not set.
- Arithmetic:
  - All arithmetic is two's complement with no saturation.
  - ACC_W is sized so that no overflow occurs for any 8-bit inputs at the default SYMBOL_LEN.
- in_valid gaps are permitted in any state; count advances only on accepted samples.

Test Plan:
1. Reset and idle: Rst_n low mid-ACCUM at sample 200 -> all outputs 0 immediately (asynchronously); after release, in_ready=1. Samples without sym_start produce no sym_valid.
2. Single symbol, I=+3/Q=-1: rx = 75*sin - 25*cos over 360 samples, ref amplitude 100, sym_ready=1 -> acc_i ≈ +1350000, acc_q ≈ -450000, sym_out=4'b1001, sym_valid for 1 cycle exactly 1 cycle after the 360th sample.
3. All 16 symbols streamed back-to-back, with in_valid toggling 50% -> sym_out sequence matches the Gray map, and in_ready=0 only in each SLICE cycle.
4. Backpressure: sym_ready=0 for 2 symbols -> sym_out shows the second symbol and overrun=1. Then sym_ready=1 -> sym_valid drops, and overrun stays 1.
5. Resync: sym_start reasserted at sample 100 of a symbol -> no symbol emitted for the aborted one. The next symbol completes 360 samples after the resync and decodes correctly.
6. Boundary slicing: force accumulations of exactly 0, THRESH and -THRESH (constant rx/ref chosen so the sum is exact) -> slices 11, 10 and 01 respectively.
